tone_divider_bank: RTL
======================

# tone_divider_bank

Parametrised multi-channel programmable clock/pulse divider for the theremin tone path. Each channel divides the system clock by a runtime-loadable divisor and produces either a 50 % square wave (toggle mode) or a one-cycle strobe (pulse mode). Divisor updates are double-buffered and applied only at a period boundary, so pitch changes driven by the sensor/pot front end never glitch the audio output. It sits between the distance/pot-to-divisor mapping logic and the audio output pins.

## Interface
- CH, 4, number of independent divider channels (1..16)
- CH_W, 2, width of channel select; must equal max(1, ceil(log2(CH)))
- DIV_W, 26, divisor width in bits (2..32)
- RST_DIV, 24_999_999, reset value of every shadow and active divisor (1 Hz toggle at 50 MHz)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  CH  per-channel enable, level-sensitive
- mode  in  CH  per-channel mode: 0 = toggle (square wave), 1 = pulse (one-cycle strobe)
- ld  in  1  load strobe, one cycle, writes ld_div into shadow divisor of channel ld_ch
- ld_ch  in  CH_W  target channel of load
- ld_div  in  DIV_W  divisor value to load
- ld_ack  out  1  one-cycle pulse the cycle after an accepted load
- clk_out  out  CH  per-channel divided output, registered
- tick  out  CH  per-channel one-cycle pulse, registered, marks each period boundary

## Operation
- Per channel state: cnt[DIV_W], act_div[DIV_W] (active), shd_div[DIV_W] (shadow), clk_out bit, tick bit.
- Terminal condition term = en & (cnt == act_div).
- en high, not term: cnt <= cnt + 1.
- en high, term: cnt <= 0; act_div <= shd_div (or bypass value, below); tick <= 1.
- tick <= 0 in every cycle without term.
- Toggle mode: clk_out <= ~clk_out on term, else holds. Output period = 2*(act_div+1) cycles, duty exactly 50 %.
- Pulse mode: clk_out <= term. Output period = act_div+1 cycles; act_div = 0 gives clk_out constantly 1.
- mode sampled every cycle; switching mode never resets cnt. Toggle->pulse: clk_out goes 0 next cycle unless term. Pulse->toggle: toggling continues from current clk_out value.
- en low: cnt <= 0, clk_out <= 0, tick <= 0, act_div <= shd_div every cycle (new divisor takes effect immediately on re-enable). en rising: first term after act_div+1 cycles.
- Load: ld high and ld_ch < CH -> shd_div[ld_ch] <= ld_div; ld_ack <= 1 next cycle. ld_ch >= CH: load ignored, no ld_ack, no state change.
- Simultaneous ld to channel k and term on channel k: act_div[k] <= ld_div (bypass; newest value wins), shd_div[k] <= ld_div.
- Back-to-back loads to same channel before a boundary: last one wins; earlier values never become active.
- cnt never exceeds act_div; act_div only changes at term or while disabled, so no wrap-around of cnt is possible.
- ld_ack asserts for every accepted load, including back-to-back; no ready/backpressure (always ready).

## Timing
- Reset (rst low, asynchronous, any time): cnt = 0, shd_div = act_div = RST_DIV, clk_out = 0, tick = 0, ld_ack = 0 for all channels, effective immediately. Reset mid-period discards pending shadow values.
- First rising edge after rst deasserts is a normal counting edge.
- Load latency: shadow written at edge where ld sampled; ld_ack high one cycle later; value active at next term of that channel.
- clk_out and tick change on the same edge following term; tick and clk_out rise together in toggle mode only on odd boundaries (clk_out 0->1).
- Channels fully independent; no inter-channel skew beyond divisor differences; identical divisors with simultaneous enable stay phase-locked.

## Test plan
- Reset/defaults: DIV_W=4, RST_DIV=3, en=1 all, mode=0 -> clk_out toggles every 4 cycles (period 8), tick every 4 cycles; rst low mid-period -> all outputs 0 in same cycle.
- Glitch-free reload: ch0 div=9 running toggle, load ld_div=2 at cnt=4 -> ld_ack next cycle, current half-period completes at 10 cycles, following half-periods are 3 cycles.
- Pulse mode: ch1 mode=1, div=4 -> clk_out high 1 cycle every 5; div=0 -> clk_out stuck 1, tick stuck 1.
- Load/terminal collision: ld to ch2 with ld_div=6 in exact term cycle of ch2 -> next period uses 6 (7 cycles), shd_div=6.
- Disable path: en[3]=0, load ld_div=1, en[3]=1 -> clk_out 0 while disabled, first toggle 2 cycles after enable.
- Invalid channel: CH=3, CH_W=2, ld_ch=3 -> no ld_ack, all divisors unchanged, outputs undisturbed.

Source files
------------

// File: rtl/tone_divider_bank.sv
// Multi-channel programmable divider: each channel yields a 50 % square wave or a
// one-cycle strobe, with double-buffered divisors swapped only at period boundaries.
module tone_divider_bank #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned DIV_W   = 26,
  parameter int unsigned RST_DIV = 24_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    mode,
  input  logic             ld,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [DIV_W-1:0] ld_div,
  output logic             ld_ack,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick
);

  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);

  logic w_ld_ok;
  logic r_ld_ack;

  // Loads addressed beyond the last channel are silently dropped and not acknowledged.
  assign w_ld_ok = ld && (32'(ld_ch) < CH);
  assign ld_ack  = r_ld_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_ack <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values; blocking here would create order-dependent simulation races.
      r_ld_ack <= w_ld_ok;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_act_div;
    logic [DIV_W-1:0] r_shd_div;
    logic             r_out;
    logic             r_tick;
    logic             w_hit;
    logic             w_term;

    assign w_hit  = w_ld_ok && (ld_ch == CH_W'(i));
    assign w_term = en[i] && (r_cnt == r_act_div);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt     <= '0;
        r_act_div <= RST_VAL;
        r_shd_div <= RST_VAL;
        r_out     <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (w_hit) begin
          r_shd_div <= ld_div;
        end

        if (!en[i]) begin
          r_cnt     <= '0;
          r_out     <= 1'b0;
          r_tick    <= 1'b0;
          r_act_div <= r_shd_div;
        end else if (w_term) begin
          r_cnt     <= '0;
          // A load landing on the boundary bypasses the shadow so the newest value wins.
          r_act_div <= w_hit ? ld_div : r_shd_div;
          r_tick    <= 1'b1;
          r_out     <= mode[i] ? 1'b1 : ~r_out;
        end else begin
          r_cnt     <= r_cnt + DIV_W'(1);
          r_tick    <= 1'b0;
          r_out     <= mode[i] ? 1'b0 : r_out;
        end
      end
    end

    assign clk_out[i] = r_out;
    assign tick[i]    = r_tick;
  end

endmodule
